// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order pipeline (EX/M) and a
// long-latency unit (mul/div). Long-latency results are parked in a one-entry
// buffer and written when the pipe leaves the port free. If the pipe keeps the
// port busy for STARVE_LIMIT cycles, the pipe is stalled for a single cycle
// so that the buffered result can drain.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4  // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  pipe_rd_addr,
    input  logic [31:0] pipe_rd,
    input  logic        pipe_wb_en,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd_addr,
    input  logic [31:0] lu_rd,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic        stall
);

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    // One-entry buffer for a long-latency result
    logic        r_buf_valid;
    logic [4:0]  r_buf_addr;
    logic [31:0] r_buf_data;
    logic [3:0]  r_age;

    logic        w_buf_valid_nxt;
    logic [4:0]  w_buf_addr_nxt;
    logic [31:0] w_buf_data_nxt;
    logic [3:0]  w_age_nxt;

    logic        w_pipe_want;
    logic        w_stall;
    logic        w_lu_ready;
    logic        w_pipe_wr;
    logic        w_buf_wr;
    logic        w_handshake;
    logic        w_waw_kill;

    // Port selection and handshake; everything is gated to zero while in reset
    always_comb begin
        w_pipe_want = pipe_wb_en && (pipe_rd_addr != 5'd0);
        w_stall     = rst && r_buf_valid && (r_age == LP_LIMIT) && w_pipe_want;
        w_lu_ready  = rst && !r_buf_valid;
        w_pipe_wr   = rst && w_pipe_want && !w_stall;
        w_buf_wr    = rst && !w_pipe_wr && r_buf_valid;
        w_handshake = lu_valid && w_lu_ready;
        // Younger pipe result to the same register makes the buffered one dead
        w_waw_kill  = w_pipe_wr && r_buf_valid && (pipe_rd_addr == r_buf_addr);

        rf_we   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (w_pipe_wr) begin
            rf_we   = 1'b1;
            rf_addr = pipe_rd_addr;
            rf_data = pipe_rd;
        end else if (w_buf_wr) begin
            rf_we   = 1'b1;
            rf_addr = r_buf_addr;
            rf_data = r_buf_data;
        end

        stall    = w_stall;
        lu_ready = w_lu_ready;
    end

    // Buffer next state: load on handshake, clear on drain or WAW, age while waiting
    always_comb begin
        w_buf_valid_nxt = r_buf_valid;
        w_buf_addr_nxt  = r_buf_addr;
        w_buf_data_nxt  = r_buf_data;
        w_age_nxt       = r_age;

        if (w_handshake) begin
            // lu_ready implies the buffer is empty here. x0 results and results
            // overwritten by a same-cycle pipe write to the same register are dropped.
            if ((lu_rd_addr != 5'd0) && !(w_pipe_wr && (pipe_rd_addr == lu_rd_addr))) begin
                w_buf_valid_nxt = 1'b1;
                w_buf_addr_nxt  = lu_rd_addr;
                w_buf_data_nxt  = lu_rd;
                w_age_nxt       = 4'd0;
            end
        end else if (r_buf_valid) begin
            if (w_buf_wr || w_waw_kill) begin
                w_buf_valid_nxt = 1'b0;
                w_age_nxt       = 4'd0;
            end else if (r_age != LP_LIMIT) begin
                w_age_nxt = r_age + 4'd1;
            end
        end
    end

    // Buffer state register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= 5'd0;
            r_buf_data  <= 32'd0;
            r_age       <= 4'd0;
        end else begin
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_addr  <= w_buf_addr_nxt;
            r_buf_data  <= w_buf_data_nxt;
            r_age       <= w_age_nxt;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter (STARVE_LIMIT = 4).
// Inputs change on the falling edge; outputs are compared 2 time units later,
// well before the next rising edge.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic [4:0]  pipe_rd_addr;
    logic [31:0] pipe_rd;
    logic        pipe_wb_en;
    logic        lu_valid;
    logic [4:0]  lu_rd_addr;
    logic [31:0] lu_rd;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        stall;

    int n_tests;
    int n_fail;

    wb_port_arbiter #(
        .STARVE_LIMIT(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_rd_addr(pipe_rd_addr),
        .pipe_rd     (pipe_rd),
        .pipe_wb_en  (pipe_wb_en),
        .lu_valid    (lu_valid),
        .lu_rd_addr  (lu_rd_addr),
        .lu_rd       (lu_rd),
        .lu_ready    (lu_ready),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pwe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_stall;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic e_rdy, input logic e_we, input logic [4:0] e_addr,
                                input logic [31:0] e_data, input logic e_stall);
        vec_t v;
        v.pwe = pwe; v.pa = pa; v.pd = pd; v.lv = lv; v.la = la; v.ld = ld;
        v.e_rdy = e_rdy; v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
        v.e_stall = e_stall;
        return v;
    endfunction

    task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_wb_en   = pwe;
        pipe_rd_addr = pa;
        pipe_rd      = pd;
        lu_valid     = lv;
        lu_rd_addr   = la;
        lu_rd        = ld;
    endtask

    task automatic check(input string name, input logic e_rdy, input logic e_we,
                         input logic [4:0] e_addr, input logic [31:0] e_data,
                         input logic e_stall);
        n_tests++;
        if (lu_ready !== e_rdy || rf_we !== e_we || rf_addr !== e_addr ||
            rf_data !== e_data || stall !== e_stall) begin
            n_fail++;
            $display("FAIL %s: got rdy=%0b we=%0b addr=%0d data=%h stall=%0b, want rdy=%0b we=%0b addr=%0d data=%h stall=%0b",
                     name, lu_ready, rf_we, rf_addr, rf_data, stall,
                     e_rdy, e_we, e_addr, e_data, e_stall);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Idle-pipe single result: x5 = 0x1234
        vecs[0]  = mk(0, 0, 0,        1, 5, 32'h1234, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0,        0, 0, 0,        0, 1, 5, 32'h1234, 0);
        vecs[2]  = mk(0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0);
        // Pipe writes x3 every cycle; x7 = 0xAA starves for 4 cycles then stalls
        vecs[3]  = mk(1, 3, 32'h33,   1, 7, 32'hAA,   1, 1, 3, 32'h33, 0);
        vecs[4]  = mk(1, 3, 32'h33,   0, 0, 0,        0, 1, 3, 32'h33, 0);
        vecs[5]  = mk(1, 3, 32'h33,   0, 0, 0,        0, 1, 3, 32'h33, 0);
        vecs[6]  = mk(1, 3, 32'h33,   0, 0, 0,        0, 1, 3, 32'h33, 0);
        vecs[7]  = mk(1, 3, 32'h33,   0, 0, 0,        0, 1, 3, 32'h33, 0);
        vecs[8]  = mk(1, 3, 32'h33,   0, 0, 0,        0, 1, 7, 32'hAA, 1);
        vecs[9]  = mk(1, 3, 32'h33,   0, 0, 0,        1, 1, 3, 32'h33, 0);
        vecs[10] = mk(0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0);
        // WAW: buffered x9 = 0x55 killed by pipe x9 = 0x66
        vecs[11] = mk(0, 0, 0,        1, 9, 32'h55,   1, 0, 0, 0, 0);
        vecs[12] = mk(1, 9, 32'h66,   0, 0, 0,        0, 1, 9, 32'h66, 0);
        vecs[13] = mk(0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0);
        // x0 from both sides is never written
        vecs[14] = mk(1, 0, 32'h11,   1, 0, 32'hFF,   1, 0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0);
        // Same-cycle pipe write and handshake to x12: LU result discarded
        vecs[16] = mk(1, 12, 32'hC,   1, 12, 32'hD,   1, 1, 12, 32'hC, 0);
        vecs[17] = mk(0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0);
        // lu_valid held while buffer full; accepted after drain, written a cycle later
        vecs[18] = mk(1, 1, 32'h10,   1, 2, 32'h20,   1, 1, 1, 32'h10, 0);
        vecs[19] = mk(1, 1, 32'h10,   1, 6, 32'h60,   0, 1, 1, 32'h10, 0);
        vecs[20] = mk(0, 0, 0,        1, 6, 32'h60,   0, 1, 2, 32'h20, 0);
        vecs[21] = mk(0, 0, 0,        1, 6, 32'h60,   1, 0, 0, 0, 0);
        vecs[22] = mk(0, 0, 0,        0, 0, 0,        0, 1, 6, 32'h60, 0);
        vecs[23] = mk(0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0);

        // Reset with active-looking inputs: every output must be zero
        rst = 1'b0;
        drive(1, 3, 32'h33, 1, 4, 32'h44);
        #2;
        check("reset_outputs", 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        check("reset_held", 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        check("first_cycle_after_release", 1, 0, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld);
            #2;
            check($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_we, vecs[i].e_addr,
                  vecs[i].e_data, vecs[i].e_stall);
        end

        // Mid-operation reset: buffered x4 must be lost
        @(negedge clk);
        drive(1, 3, 32'h33, 1, 4, 32'h44);
        #2;
        check("rst_seq_load", 1, 1, 3, 32'h33, 0);
        @(negedge clk);
        drive(1, 3, 32'h33, 0, 0, 0);
        #2;
        check("rst_seq_buffered", 0, 1, 3, 32'h33, 0);
        #1;
        rst = 1'b0;
        #1;
        check("rst_seq_async_zero", 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("rst_seq_during", 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("rst_seq_release", 1, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        check("rst_seq_no_x4_write", 1, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        check("rst_seq_still_idle", 1, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of cycles a buffered long-latency result may wait before it forces a pipeline stall (legal range 1..15).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-low (rst=0 resets).
REQ-004 SHALL have port pipe_rd_addr  in  5  destination register of the instruction in the EX/M register.
REQ-005 SHALL have port pipe_rd  in  32  result value from the EX/M register.
REQ-006 SHALL have port pipe_wb_en  in  1  the EX/M instruction requests a register write.
REQ-007 SHALL have port lu_valid  in  1  the long-latency unit (mul/div) presents a result.
REQ-008 SHALL have port lu_rd_addr  in  5  destination register of the long-latency result.
REQ-009 SHALL have port lu_rd  in  32  long-latency result value.
REQ-010 SHALL have port lu_ready  out  1  the arbiter accepts the long-latency result this cycle.
REQ-011 SHALL have port rf_we  out  1  register-file write enable.
REQ-012 SHALL have port rf_addr  out  5  register-file write address.
REQ-013 SHALL have port rf_data  out  32  register-file write data.
REQ-014 SHALL have port stall  out  1  the EX/M register and all upstream stages hold; the current pipe write is not performed.

Function
REQ-015 SHALL hold a one-entry buffer: buf_valid, buf_addr[4:0], buf_data[31:0], age counter[3:0].
REQ-016 SHALL derive pipe_want = pipe_wb_en && (pipe_rd_addr != 0); x0 writes are never performed.
REQ-017 SHALL drive lu_ready = !buf_valid, combinationally; handshake completes on lu_valid && lu_ready at the clock edge.
REQ-018 SHALL, on handshake with lu_rd_addr != 0 and not (pipe_want && !stall && pipe_rd_addr == lu_rd_addr), load the buffer (buf_valid=1, age=0); otherwise the accepted result is discarded.
REQ-019 SHALL never write an accepted result in its acceptance cycle; minimum latency from handshake to rf_we is 1 cycle.
REQ-020 SHALL assert stall = buf_valid && age == STARVE_LIMIT && pipe_want, combinationally.
REQ-021 SHALL select the write port combinationally: if pipe_want && !stall, write pipe_rd_addr/pipe_rd; else if buf_valid, write buf_addr/buf_data and clear buf_valid at the edge; else rf_we=0.
REQ-022 SHALL drive rf_addr=0 and rf_data=0 whenever rf_we=0.
REQ-023 SHALL increment age each cycle buf_valid remains set and is not drained, saturating at STARVE_LIMIT.
REQ-024 SHALL, when pipe writes (pipe_want && !stall) with pipe_rd_addr == buf_addr and buf_valid, clear buf_valid without writing the buffer; the younger pipe result wins (WAW).
REQ-025 SHALL keep stall high for exactly one cycle per starvation event; the buffered write happens in that cycle and the stalled pipe write occurs the next cycle.
REQ-026 SHALL not depend on stall feedback: the held EX/M values re-presented after a stall are treated as a fresh request.

Reset
REQ-027 SHALL, while rst=0, force buf_valid=0, buf_addr=0, buf_data=0, age=0, regardless of clk.
REQ-028 SHALL, while rst=0, drive rf_we=0, rf_addr=0, rf_data=0, stall=0, lu_ready=0.
REQ-029 SHALL discard any buffered result when reset asserts mid-operation; no write of it occurs after reset release.
REQ-030 SHALL assert lu_ready=1 in the first cycle after reset release.

Verification
REQ-031 Idle pipe, lu_valid with x5=0x1234 -> lu_ready=1; next cycle rf_we=1, rf_addr=5, rf_data=0x1234; then lu_ready=1.
REQ-032 Pipe writes x3 every cycle, LU delivers x7=0xAA -> buffer waits 4 cycles; 5th cycle stall=1, rf writes x7=0xAA; next cycle rf writes x3.
REQ-033 Buffer holds x9=0x55, pipe writes x9=0x66 -> rf writes x9=0x66; buffer cleared; x9=0x55 never written; lu_ready=1 next cycle.
REQ-034 LU delivers x0=0xFF, pipe writes x0 -> rf_we stays 0; buffer stays empty.
REQ-035 Buffer holds x4, rst pulsed low mid-cycle -> outputs zero immediately; after release no write to x4; lu_ready=1.
REQ-036 lu_valid held high with buffer full -> lu_ready=0; result accepted the cycle after drain, written one cycle later.
